// File: rtl/mem_test_pkg.sv
// Shared encodings and constants for the memory-test sequencer.
package mem_test_pkg;

    typedef enum logic [3:0] {
        ST_IDLE    = 4'd0,
        ST_WR_CMD  = 4'd1,
        ST_RD_CMD  = 4'd2,
        ST_RD_WAIT = 4'd3,
        ST_CMP     = 4'd4,
        ST_REP     = 4'd5,
        ST_REP_LO  = 4'd6,
        ST_REP_HI  = 4'd7,
        ST_NEXT    = 4'd8,
        ST_DONE    = 4'd9
    } state_e;

    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;
    localparam logic [31:0] TIMEOUT_DATA = 32'hDEAD_DEAD;
    localparam logic [31:0] PATTERN_XOR  = 32'hA5A5_A5A5;

    function automatic logic [31:0] lfsr_next(input logic [31:0] q);
        return q[0] ? ((q >> 1) ^ LFSR_POLY) : (q >> 1);
    endfunction

endpackage

// File: rtl/mem_test_lfsr32.sv
// 32-bit Galois LFSR data generator; load has priority over step.
module mem_test_lfsr32
    import mem_test_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_load,
    input  logic [31:0] i_seed,
    input  logic        i_step,
    output logic [31:0] o_q
);

    logic [31:0] q_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            q_q <= '0;
        end else if (i_load) begin
            q_q <= i_seed;
        end else if (i_step) begin
            q_q <= lfsr_next(q_q);
        end
    end

    assign o_q = q_q;

endmodule

// File: rtl/mem_test_seq.sv
// Memory-test sequencer: write pattern, read back, report each mismatch to the printer.
// Build option MEM_TEST_LFSR_EN selects LFSR data instead of adr ^ A5A5A5A5.
//
// state    | meaning
// IDLE     | waiting for first start
// WR_CMD   | issuing write at adr_q
// RD_CMD   | issuing read at adr_q
// RD_WAIT  | waiting for read data or timeout
// CMP      | compare captured data with expected
// REP      | waiting for printer ready, then strobe
// REP_LO   | waiting for printer to drop ready
// REP_HI   | waiting for printer to raise ready again
// NEXT     | advance address or finish
// DONE     | result valid until next start
module mem_test_seq
    import mem_test_pkg::*;
#(
    parameter logic [31:0] ADR_START  = 32'h0000_0000,
    parameter logic [31:0] ADR_END    = 32'h0000_FFFC,
    parameter logic [31:0] ADR_STEP   = 32'd4,
    parameter logic [15:0] RD_TIMEOUT = 16'd1024
`ifdef MEM_TEST_LFSR_EN
    , parameter logic [31:0] LFSR_SEED = 32'h1234_5678
`endif
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    output logic        o_mem_cmd_en,
    output logic        o_mem_cmd_we,
    output logic [31:0] o_mem_adr,
    output logic [31:0] o_mem_wdata,
    input  logic        i_mem_cmd_rdy,
    input  logic        i_mem_rd_valid,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_rep_adr,
    output logic [31:0] o_rep_dataw,
    output logic [31:0] o_rep_datar,
    output logic        o_rep_we,
    input  logic        i_rep_ready,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [15:0] o_err_cnt
);

    state_e      state_q;
    logic [31:0] adr_q;
    logic        cmd_en_q;
    logic        cmd_we_q;
    logic [15:0] tmo_q;
    logic [31:0] rdata_q;
    logic        force_q;
    logic [31:0] rep_adr_q;
    logic [31:0] rep_dataw_q;
    logic [31:0] rep_datar_q;
    logic        rep_we_q;
    logic        busy_q;
    logic        done_q;
    logic        pass_q;
    logic [15:0] err_cnt_q;

    logic        cmd_acc_d;
    logic        last_adr_d;
    logic [32:0] adr_inc_d;
    logic [31:0] exp_data_d;
    logic        mismatch_d;

    assign cmd_acc_d  = cmd_en_q & i_mem_cmd_rdy;
    assign last_adr_d = (adr_q == ADR_END);
    assign adr_inc_d  = {1'b0, adr_q} + {1'b0, ADR_STEP};
    assign mismatch_d = force_q | (rdata_q != exp_data_d);

`ifdef MEM_TEST_LFSR_EN
    logic lfsr_load_d;
    logic lfsr_step_d;

    // Reload at the start of each pass so the read pass replays the write sequence.
    assign lfsr_load_d = (((state_q == ST_IDLE) || (state_q == ST_DONE)) && i_start)
                       || ((state_q == ST_WR_CMD) && cmd_acc_d && last_adr_d);
    assign lfsr_step_d = ((state_q == ST_WR_CMD) && cmd_acc_d && !last_adr_d)
                       || (state_q == ST_CMP);

    mem_test_lfsr32 u_lfsr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_load (lfsr_load_d),
        .i_seed (LFSR_SEED),
        .i_step (lfsr_step_d),
        .o_q    (exp_data_d)
    );
`else
    assign exp_data_d = adr_q ^ PATTERN_XOR;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            adr_q       <= '0;
            cmd_en_q    <= 1'b0;
            cmd_we_q    <= 1'b0;
            tmo_q       <= '0;
            rdata_q     <= '0;
            force_q     <= 1'b0;
            rep_adr_q   <= '0;
            rep_dataw_q <= '0;
            rep_datar_q <= '0;
            rep_we_q    <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            err_cnt_q   <= '0;
        end else begin
            rep_we_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (i_start) begin
                        state_q   <= ST_WR_CMD;
                        adr_q     <= ADR_START;
                        cmd_en_q  <= 1'b1;
                        cmd_we_q  <= 1'b1;
                        err_cnt_q <= '0;
                        pass_q    <= 1'b0;
                        done_q    <= 1'b0;
                        busy_q    <= 1'b1;
                    end
                end
                ST_WR_CMD: begin
                    if (cmd_acc_d) begin
                        if (last_adr_d) begin
                            adr_q    <= ADR_START;
                            cmd_we_q <= 1'b0;
                            state_q  <= ST_RD_CMD;
                        end else begin
                            adr_q <= adr_inc_d[31:0];
                        end
                    end
                end
                ST_RD_CMD: begin
                    if (cmd_acc_d) begin
                        cmd_en_q <= 1'b0;
                        tmo_q    <= RD_TIMEOUT - 16'd1;
                        state_q  <= ST_RD_WAIT;
                    end
                end
                ST_RD_WAIT: begin
                    // Data arriving on the terminal-count cycle still counts as data.
                    if (i_mem_rd_valid) begin
                        rdata_q <= i_mem_rdata;
                        force_q <= 1'b0;
                        state_q <= ST_CMP;
                    end else if (tmo_q == 16'd0) begin
                        rdata_q <= TIMEOUT_DATA;
                        force_q <= 1'b1;
                        state_q <= ST_CMP;
                    end else begin
                        tmo_q <= tmo_q - 16'd1;
                    end
                end
                ST_CMP: begin
                    if (mismatch_d) begin
                        if (err_cnt_q != 16'hFFFF) begin
                            err_cnt_q <= err_cnt_q + 16'd1;
                        end
                        rep_adr_q   <= adr_q;
                        rep_dataw_q <= exp_data_d;
                        rep_datar_q <= rdata_q;
                        state_q     <= ST_REP;
                    end else begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_REP: begin
                    if (i_rep_ready) begin
                        rep_we_q <= 1'b1;
                        state_q  <= ST_REP_LO;
                    end
                end
                ST_REP_LO: begin
                    if (!i_rep_ready) begin
                        state_q <= ST_REP_HI;
                    end
                end
                ST_REP_HI: begin
                    if (i_rep_ready) begin
                        state_q <= ST_NEXT;
                    end
                end
                ST_NEXT: begin
                    if (last_adr_d || adr_inc_d[32]) begin
                        state_q <= ST_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (err_cnt_q == 16'd0);
                    end else begin
                        adr_q    <= adr_inc_d[31:0];
                        cmd_en_q <= 1'b1;
                        cmd_we_q <= 1'b0;
                        state_q  <= ST_RD_CMD;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign o_mem_cmd_en = cmd_en_q;
    assign o_mem_cmd_we = cmd_we_q;
    assign o_mem_adr    = adr_q;
    // Write data is only meaningful on writes; keeping it zero otherwise also gives a zero reset value.
    assign o_mem_wdata  = cmd_we_q ? exp_data_d : 32'h0;
    assign o_rep_adr    = rep_adr_q;
    assign o_rep_dataw  = rep_dataw_q;
    assign o_rep_datar  = rep_datar_q;
    assign o_rep_we     = rep_we_q;
    assign o_busy       = busy_q;
    assign o_done       = done_q;
    assign o_pass       = pass_q;
    assign o_err_cnt    = err_cnt_q;

endmodule

// File: tb/tb_mem_test_seq.sv
// Bench for mem_test_seq: memory and printer models with a write/read/report scoreboard.
module tb_mem_test_seq;

    localparam logic [31:0] TB_ADR_END = 32'h0000_003C;
    localparam logic [31:0] DEAD       = 32'hDEAD_DEAD;
    localparam int          NWORDS     = 16;
`ifdef MEM_TEST_LFSR_EN
    localparam logic [31:0] TB_SEED    = 32'h1234_5678;
`else
    localparam logic [31:0] PAT_XOR    = 32'hA5A5_A5A5;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        cmd_rdy = 1'b1;
    logic        model_valid = 1'b0;
    logic        late_valid = 1'b0;
    logic [31:0] model_rdata = '0;
    logic [31:0] late_data = '0;
    logic        rep_ready = 1'b1;
    logic        rd_valid;
    logic [31:0] rdata;

    logic        o_mem_cmd_en, o_mem_cmd_we, o_rep_we, o_busy, o_done, o_pass;
    logic [31:0] o_mem_adr, o_mem_wdata, o_rep_adr, o_rep_dataw, o_rep_datar;
    logic [15:0] o_err_cnt;

    assign rd_valid = model_valid | late_valid;
    assign rdata    = late_valid ? late_data : model_rdata;

    mem_test_seq #(.ADR_END(TB_ADR_END)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_start        (start),
        .o_mem_cmd_en   (o_mem_cmd_en),
        .o_mem_cmd_we   (o_mem_cmd_we),
        .o_mem_adr      (o_mem_adr),
        .o_mem_wdata    (o_mem_wdata),
        .i_mem_cmd_rdy  (cmd_rdy),
        .i_mem_rd_valid (rd_valid),
        .i_mem_rdata    (rdata),
        .o_rep_adr      (o_rep_adr),
        .o_rep_dataw    (o_rep_dataw),
        .o_rep_datar    (o_rep_datar),
        .o_rep_we       (o_rep_we),
        .i_rep_ready    (rep_ready),
        .o_busy         (o_busy),
        .o_done         (o_done),
        .o_pass         (o_pass),
        .o_err_cnt      (o_err_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    bit          rdy_random = 1'b0;
    bit          flip_en = 1'b0, drop_en = 1'b0;
    logic [31:0] flip_adr = '0, drop_adr = '0;
    int          hold_cycles = 3;

    logic [31:0] exp_wr_adr[$];
    logic [31:0] exp_wr_data[$];
    logic [31:0] exp_rd_adr[$];
    logic [95:0] exp_rep[$];

    int n_wr = 0, n_rd = 0, n_strobe = 0, n_stall = 0;
    int viol_stable = 0, viol_idle = 0;
    int drop_cyc = 0, flip_rdv_cyc = 0, strobe_cyc = 0;

    logic [31:0] mem [0:NWORDS-1];
    bit          rd_pend = 1'b0, rd_flip = 1'b0, prev_stall = 1'b0, prev_we = 1'b0;
    int          rd_lat = 0, pr_state = 0, pr_cnt = 0;
    logic [31:0] rd_val = '0, prev_adr = '0, prev_wdata = '0;
    logic [31:0] sb_a, sb_d;
    logic [95:0] sb_e;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] pat(input int idx);
`ifdef MEM_TEST_LFSR_EN
        logic [31:0] q;
        q = TB_SEED;
        for (int k = 0; k < idx; k++) q = q[0] ? ((q >> 1) ^ 32'h8020_0003) : (q >> 1);
        return q;
`else
        return (32'(idx) << 2) ^ PAT_XOR;
`endif
    endfunction

    // Memory model, printer model and scoreboard; DUT outputs are stable at the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            model_valid = 1'b0;
            rd_pend     = 1'b0;
            prev_stall  = 1'b0;
            pr_state    = 0;
            rep_ready   = 1'b1;
        end else begin
            if (prev_stall && !(o_mem_cmd_en && o_mem_cmd_we == prev_we &&
                                o_mem_adr == prev_adr && o_mem_wdata == prev_wdata))
                viol_stable++;
            cmd_rdy = rdy_random ? ($urandom_range(0, 1) == 1) : 1'b1;
            model_valid = 1'b0;
            if (rd_pend) begin
                if (rd_lat == 0) begin
                    model_valid = 1'b1;
                    model_rdata = rd_val;
                    rd_pend     = 1'b0;
                    if (rd_flip) flip_rdv_cyc = cyc;
                end else begin
                    rd_lat--;
                end
            end
            if (o_mem_cmd_en && cmd_rdy) begin
                checks++;
                if (o_mem_cmd_we) begin
                    mem[o_mem_adr[5:2]] = o_mem_wdata;
                    n_wr++;
                    if (exp_wr_adr.size() == 0) begin
                        errors++;
                        $display("FAIL wr_extra: got write adr=%h data=%h, expected none", o_mem_adr, o_mem_wdata);
                    end else begin
                        sb_a = exp_wr_adr.pop_front();
                        sb_d = exp_wr_data.pop_front();
                        if (o_mem_adr !== sb_a || o_mem_wdata !== sb_d) begin
                            errors++;
                            $display("FAIL wr_cmd: got adr=%h data=%h, expected adr=%h data=%h",
                                     o_mem_adr, o_mem_wdata, sb_a, sb_d);
                        end
                    end
                end else begin
                    n_rd++;
                    if (exp_rd_adr.size() == 0) begin
                        errors++;
                        $display("FAIL rd_extra: got read adr=%h, expected none", o_mem_adr);
                    end else begin
                        sb_a = exp_rd_adr.pop_front();
                        if (o_mem_adr !== sb_a) begin
                            errors++;
                            $display("FAIL rd_cmd: got adr=%h, expected adr=%h", o_mem_adr, sb_a);
                        end
                    end
                    if (drop_en && o_mem_adr == drop_adr) begin
                        drop_cyc = cyc;
                    end else begin
                        rd_pend = 1'b1;
                        rd_lat  = 1;
                        rd_flip = flip_en && (o_mem_adr == flip_adr);
                        rd_val  = mem[o_mem_adr[5:2]] ^ {31'b0, rd_flip};
                    end
                end
            end
            prev_stall = o_mem_cmd_en && !cmd_rdy;
            if (prev_stall) n_stall++;
            prev_we    = o_mem_cmd_we;
            prev_adr   = o_mem_adr;
            prev_wdata = o_mem_wdata;

            if (pr_state != 0 && (o_rep_we || o_mem_cmd_en)) viol_idle++;
            case (pr_state)
                0: if (o_rep_we) begin
                    n_strobe++;
                    strobe_cyc = cyc;
                    checks++;
                    if (exp_rep.size() == 0) begin
                        errors++;
                        $display("FAIL rep_extra: got adr=%h dataw=%h datar=%h, expected none",
                                 o_rep_adr, o_rep_dataw, o_rep_datar);
                    end else begin
                        sb_e = exp_rep.pop_front();
                        if ({o_rep_adr, o_rep_dataw, o_rep_datar} !== sb_e) begin
                            errors++;
                            $display("FAIL rep: got adr=%h dataw=%h datar=%h, expected adr=%h dataw=%h datar=%h",
                                     o_rep_adr, o_rep_dataw, o_rep_datar, sb_e[95:64], sb_e[63:32], sb_e[31:0]);
                        end
                    end
                    pr_state = 1;
                end
                1: begin
                    rep_ready = 1'b0;
                    pr_cnt    = hold_cycles;
                    pr_state  = 2;
                end
                default: begin
                    if (pr_cnt <= 1) begin
                        rep_ready = 1'b1;
                        pr_state  = 0;
                    end else begin
                        pr_cnt--;
                    end
                end
            endcase
        end
    end

    task automatic load_exp(input bit fl_en, input logic [31:0] fl_adr,
                            input bit dr_en, input logic [31:0] dr_adr);
        logic [31:0] a, d;
        exp_wr_adr.delete();
        exp_wr_data.delete();
        exp_rd_adr.delete();
        exp_rep.delete();
        for (int i = 0; i < NWORDS; i++) begin
            a = 32'(i) << 2;
            d = pat(i);
            exp_wr_adr.push_back(a);
            exp_wr_data.push_back(d);
            exp_rd_adr.push_back(a);
            if (fl_en && a == fl_adr) exp_rep.push_back({a, d, d ^ 32'h1});
            if (dr_en && a == dr_adr) exp_rep.push_back({a, d, DEAD});
        end
        flip_en  = fl_en;
        flip_adr = fl_adr;
        drop_en  = dr_en;
        drop_adr = dr_adr;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (o_done) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({o_mem_cmd_en, o_mem_cmd_we, o_rep_we, o_busy, o_done, o_pass} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b, expected 000000",
                     {o_mem_cmd_en, o_mem_cmd_we, o_rep_we, o_busy, o_done, o_pass});
        end
        checks++;
        if (o_mem_adr !== 32'h0 || o_mem_wdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_mem: got adr=%h wdata=%h, expected 0", o_mem_adr, o_mem_wdata);
        end
        checks++;
        if ({o_rep_adr, o_rep_dataw, o_rep_datar} !== 96'h0) begin
            errors++;
            $display("FAIL reset_rep: got %h %h %h, expected 0", o_rep_adr, o_rep_dataw, o_rep_datar);
        end
        checks++;
        if (o_err_cnt !== 16'h0) begin
            errors++;
            $display("FAIL reset_err_cnt: got %h, expected 0", o_err_cnt);
        end
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (o_busy !== 1'b0 || o_mem_cmd_en !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got busy=%b cmd_en=%b, expected 0 0", o_busy, o_mem_cmd_en);
        end
    endtask

    task automatic check_end(input string name, input bit ok, input bit pass_e, input logic [15:0] err_e);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_done: o_done not seen within cycle budget, expected 1", name);
        end
        checks++;
        if (o_pass !== pass_e || o_err_cnt !== err_e) begin
            errors++;
            $display("FAIL %s_result: got pass=%b err_cnt=%0d, expected pass=%b err_cnt=%0d",
                     name, o_pass, o_err_cnt, pass_e, err_e);
        end
        checks++;
        if (exp_wr_adr.size() != 0 || exp_rd_adr.size() != 0 || exp_rep.size() != 0) begin
            errors++;
            $display("FAIL %s_outstanding: got wr=%0d rd=%0d rep=%0d left, expected 0 0 0",
                     name, exp_wr_adr.size(), exp_rd_adr.size(), exp_rep.size());
        end
    endtask

    task automatic test_ideal();
        bit ok;
        int s0, w0, r0;
        s0 = n_strobe; w0 = n_wr; r0 = n_rd;
        load_exp(1'b0, '0, 1'b0, '0);
        pulse_start();
        repeat (20) @(negedge clk);
        checks++;
        if (o_busy !== 1'b1) begin
            errors++;
            $display("FAIL ideal_busy: got %b, expected 1", o_busy);
        end
        pulse_start();
        wait_done(5000, ok);
        check_end("ideal", ok, 1'b1, 16'd0);
        checks++;
        if (n_strobe != s0 || n_wr - w0 != 16 || n_rd - r0 != 16) begin
            errors++;
            $display("FAIL ideal_counts: got strobes=%0d writes=%0d reads=%0d, expected 0 16 16",
                     n_strobe - s0, n_wr - w0, n_rd - r0);
        end
    endtask

    task automatic test_mismatch();
        bit ok;
        int s0;
        s0 = n_strobe;
        load_exp(1'b1, 32'h10, 1'b0, '0);
        pulse_start();
        wait_done(5000, ok);
        check_end("mismatch", ok, 1'b0, 16'd1);
        checks++;
        if (n_strobe - s0 != 1 || strobe_cyc - flip_rdv_cyc < 2 || strobe_cyc - flip_rdv_cyc > 3) begin
            errors++;
            $display("FAIL mismatch_strobe: got %0d strobes latency=%0d, expected 1 strobe latency 2..3",
                     n_strobe - s0, strobe_cyc - flip_rdv_cyc);
        end
    endtask

    task automatic test_timeout();
        bit ok;
        load_exp(1'b0, '0, 1'b1, 32'h20);
        pulse_start();
        wait_done(5000, ok);
        check_end("timeout", ok, 1'b0, 16'd1);
        checks++;
        if (strobe_cyc - drop_cyc < 1026 || strobe_cyc - drop_cyc > 1028) begin
            errors++;
            $display("FAIL timeout_delay: got %0d cycles from read to strobe, expected 1026..1028",
                     strobe_cyc - drop_cyc);
        end
    endtask

    task automatic test_printer_stall();
        bit ok;
        int s0;
        s0 = n_strobe;
        hold_cycles = 5000;
        viol_idle = 0;
        load_exp(1'b1, 32'h30, 1'b0, '0);
        pulse_start();
        wait_done(20000, ok);
        check_end("stall", ok, 1'b0, 16'd1);
        checks++;
        if (viol_idle != 0 || n_strobe - s0 != 1) begin
            errors++;
            $display("FAIL stall_quiet: got %0d activity cycles while ready low, %0d strobes; expected 0 and 1",
                     viol_idle, n_strobe - s0);
        end
        hold_cycles = 3;
    endtask

    task automatic test_reset_midrun();
        bit ok;
        int r0, s0, bad;
        r0 = n_rd;
        s0 = n_strobe;
        load_exp(1'b0, '0, 1'b1, 32'h08);
        exp_rep.delete();
        pulse_start();
        ok = 1'b0;
        for (int i = 0; i < 500; i++) begin
            @(negedge clk);
            if (n_rd - r0 >= 3) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
        checks++;
        if (!ok || o_busy !== 1'b1) begin
            errors++;
            $display("FAIL midrun_reach: got reached=%b busy=%b, expected 1 1", ok, o_busy);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        late_valid = 1'b1;
        late_data  = 32'h0BAD_F00D;
        @(negedge clk);
        late_valid = 1'b0;
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (o_mem_cmd_en || o_busy || o_rep_we || o_done) bad++;
        end
        checks++;
        if (bad != 0 || o_err_cnt !== 16'h0 || o_pass !== 1'b0 || n_strobe != s0) begin
            errors++;
            $display("FAIL midrun_idle: got active=%0d err_cnt=%0d pass=%b strobes=%0d, expected 0 0 0 0",
                     bad, o_err_cnt, o_pass, n_strobe - s0);
        end
        load_exp(1'b0, '0, 1'b0, '0);
        pulse_start();
        wait_done(5000, ok);
        check_end("rerun", ok, 1'b1, 16'd0);
    endtask

    task automatic test_backpressure();
        bit ok;
        int st0;
        st0 = n_stall;
        viol_stable = 0;
        rdy_random = 1'b1;
        load_exp(1'b0, '0, 1'b0, '0);
        pulse_start();
        wait_done(10000, ok);
        rdy_random = 1'b0;
        check_end("bp", ok, 1'b1, 16'd0);
        checks++;
        if (viol_stable != 0 || n_stall == st0) begin
            errors++;
            $display("FAIL bp_stable: got %0d unstable cycles over %0d stalls, expected 0 over >0",
                     viol_stable, n_stall - st0);
        end
    endtask

    initial begin
        test_reset();
        test_ideal();
        test_mismatch();
        test_timeout();
        test_printer_stall();
        test_reset_midrun();
        test_backpressure();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
